// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - block copy engine mastering a single-port data memory
// Optional constant-fill mode is compiled in with MEM_COPY_FILL_EN.
module mem_copy_dma #(
    parameter int AD = 5,
    parameter int C  = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [AD-1:0] i_src_addr,
    input  logic [AD-1:0] i_dst_addr,
    input  logic [AD:0]   i_len,
`ifdef MEM_COPY_FILL_EN
    input  logic          i_fill_mode,
    input  logic [C-1:0]  i_fill_pattern,
`endif
    output logic          o_busy,
    output logic          o_done,
    output logic          o_mem_en,
    output logic          o_mem_wr_rd,
    output logic [AD-1:0] o_mem_addr,
    output logic [C-1:0]  o_mem_din,
    input  logic [C-1:0]  i_mem_dout
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;

    state_t        r_state;
    logic [AD-1:0] r_src;
    logic [AD-1:0] r_dst;
    logic [AD:0]   r_len;
    logic [AD:0]   r_i;

    logic          w_start_fill;
    logic          w_fill;
    logic [C-1:0]  w_fill_pat;
    logic [AD:0]   w_i_next;
    logic          w_last;
    logic [AD-1:0] w_dst_cur;
    logic [AD-1:0] w_src_next;
    logic [AD-1:0] w_dst_next;

`ifdef MEM_COPY_FILL_EN
    logic r_fill;
    assign w_start_fill = i_fill_mode;
    assign w_fill       = r_fill;
    assign w_fill_pat   = i_fill_pattern;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_fill <= 1'b0;
        else if (r_state == S_IDLE && i_start)
            r_fill <= i_fill_mode;
    end
`else
    assign w_start_fill = 1'b0;
    assign w_fill       = 1'b0;
    assign w_fill_pat   = '0;
`endif

    // Addresses wrap naturally by truncation to AD bits.
    assign w_i_next   = r_i + {{AD{1'b0}}, 1'b1};
    assign w_last     = (w_i_next == r_len);
    assign w_dst_cur  = r_dst + r_i[AD-1:0];
    assign w_src_next = r_src + w_i_next[AD-1:0];
    assign w_dst_next = r_dst + w_i_next[AD-1:0];

    // Outputs are loaded on the edge entering a state, so they are valid for
    // the whole cycle spent in it. o_mem_din doubles as the data register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_i         <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_mem_en    <= 1'b0;
            o_mem_wr_rd <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_din   <= '0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    o_mem_en <= 1'b0;
                    o_busy   <= 1'b0;
                    if (i_start) begin
                        r_src <= i_src_addr;
                        r_dst <= i_dst_addr;
                        r_len <= i_len;
                        r_i   <= '0;
                        if (i_len == '0) begin
                            r_state <= S_DONE;
                            o_done  <= 1'b1;
                        end else if (w_start_fill) begin
                            r_state     <= S_WR;
                            o_busy      <= 1'b1;
                            o_mem_en    <= 1'b1;
                            o_mem_wr_rd <= 1'b1;
                            o_mem_addr  <= i_dst_addr;
                            o_mem_din   <= w_fill_pat;
                        end else begin
                            r_state     <= S_RD;
                            o_busy      <= 1'b1;
                            o_mem_en    <= 1'b1;
                            o_mem_wr_rd <= 1'b0;
                            o_mem_addr  <= i_src_addr;
                        end
                    end
                end
                S_RD: begin
                    r_state  <= S_WAIT;
                    o_mem_en <= 1'b0;
                end
                S_WAIT: begin
                    r_state     <= S_WR;
                    o_mem_en    <= 1'b1;
                    o_mem_wr_rd <= 1'b1;
                    o_mem_addr  <= w_dst_cur;
                    o_mem_din   <= i_mem_dout;
                end
                S_WR: begin
                    r_i <= w_i_next;
                    if (w_last) begin
                        r_state  <= S_DONE;
                        o_busy   <= 1'b0;
                        o_mem_en <= 1'b0;
                        o_done   <= 1'b1;
                    end else if (w_fill) begin
                        o_mem_addr <= w_dst_next;
                    end else begin
                        r_state     <= S_RD;
                        o_mem_wr_rd <= 1'b0;
                        o_mem_addr  <= w_src_next;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb/tb_mem_copy_dma.sv - self-checking bench for mem_copy_dma with a behavioural memory model
module tb_mem_copy_dma;
    localparam int AD = 5;
    localparam int C  = 32;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic [AD-1:0] i_src_addr = '0;
    logic [AD-1:0] i_dst_addr = '0;
    logic [AD:0]   i_len = '0;
    logic          i_fill_mode = 1'b0;
    logic [C-1:0]  i_fill_pattern = '0;
    logic          o_busy, o_done, o_mem_en, o_mem_wr_rd;
    logic [AD-1:0] o_mem_addr;
    logic [C-1:0]  o_mem_din;
    logic [C-1:0]  rdata;

    always #5 clk = ~clk;

    mem_copy_dma #(.AD(AD), .C(C)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
        .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr), .i_len(i_len),
`ifdef MEM_COPY_FILL_EN
        .i_fill_mode(i_fill_mode), .i_fill_pattern(i_fill_pattern),
`endif
        .o_busy(o_busy), .o_done(o_done), .o_mem_en(o_mem_en),
        .o_mem_wr_rd(o_mem_wr_rd), .o_mem_addr(o_mem_addr),
        .o_mem_din(o_mem_din), .i_mem_dout(rdata)
    );

    // Data memory: registered read, write committed at the end of the cycle.
    logic [C-1:0] mem     [N];
    logic [C-1:0] pl_data [N];
    logic [C-1:0] ref_mem [N];
    logic         pl_en = 1'b0;

    always @(posedge clk) begin
        if (pl_en) begin
            for (int k = 0; k < N; k++) mem[k] <= pl_data[k];
        end else if (o_mem_en) begin
            if (o_mem_wr_rd) mem[o_mem_addr] <= o_mem_din;
            else             rdata <= mem[o_mem_addr];
        end
    end

    typedef struct {
        logic [AD-1:0] src;
        logic [AD-1:0] dst;
        logic [AD:0]   len;
        bit            fill;
        logic [C-1:0]  pat;
        int            xs;
        bit            seq;
    } vec_t;

    vec_t vt[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic vec_t mk(input int src, input int dst, input int len,
                                input bit fill, input logic [C-1:0] pat,
                                input int xs, input bit seq);
        vec_t v;
        v.src = AD'(src); v.dst = AD'(dst); v.len = (AD+1)'(len);
        v.fill = fill; v.pat = pat; v.xs = xs; v.seq = seq;
        return v;
    endfunction

    task automatic preload(input bit seq);
        for (int k = 0; k < N; k++) begin
            pl_data[k] = seq ? (32'h1000_0000 + k) : $urandom;
            ref_mem[k] = pl_data[k];
        end
        @(negedge clk); pl_en = 1'b1;
        @(negedge clk); pl_en = 1'b0;
    endtask

    task automatic compare_mem(input string name);
        int nmis = 0;
        for (int k = 0; k < N; k++) begin
            if (mem[k] !== ref_mem[k]) begin
                if (nmis == 0)
                    $display("FAIL %s: mem[%0d] got 0x%0h, expected 0x%0h", name, k, mem[k], ref_mem[k]);
                nmis++;
            end
        end
        check({name, " mismatching words"}, nmis, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc, done_cyc, busy_cnt, en_cnt, wr_cnt, post_act;
        int e_done, e_busy, e_en;
        string tag;
        tag = $sformatf("vec%0d", idx);
        preload(v.seq);
        // Reference: sequential ascending copy, so overlap re-reads written data.
        for (int i = 0; i < int'(v.len); i++) begin
            if (v.fill) ref_mem[(int'(v.dst) + i) % N] = v.pat;
            else        ref_mem[(int'(v.dst) + i) % N] = ref_mem[(int'(v.src) + i) % N];
        end
        e_done = (v.len == 0) ? 1 : (v.fill ? int'(v.len) + 1 : 3 * int'(v.len) + 1);
        e_busy = v.fill ? int'(v.len) : 3 * int'(v.len);
        e_en   = v.fill ? int'(v.len) : 2 * int'(v.len);

        @(negedge clk);
        i_src_addr = v.src; i_dst_addr = v.dst; i_len = v.len;
        i_fill_mode = v.fill; i_fill_pattern = v.pat; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        cyc = 1; done_cyc = -1; busy_cnt = 0; en_cnt = 0; wr_cnt = 0; post_act = 0;
        while (cyc < 3 * N + 20) begin
            if (o_busy) busy_cnt++;
            if (o_mem_en) en_cnt++;
            if (o_mem_en && o_mem_wr_rd) wr_cnt++;
            if (done_cyc >= 0 && (o_busy || o_mem_en || o_done)) post_act++;
            if (o_done && done_cyc < 0) done_cyc = cyc;
            if (cyc == v.xs) begin
                i_start = 1'b1; i_src_addr = 5'd5;
            end else begin
                i_start = 1'b0;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            @(posedge clk); #1;
            cyc++;
        end
        i_start = 1'b0;
        check({tag, " done cycle"}, done_cyc, e_done);
        check({tag, " busy cycles"}, busy_cnt, e_busy);
        check({tag, " mem_en cycles"}, en_cnt, e_en);
        check({tag, " write count"}, wr_cnt, int'(v.len));
        check({tag, " activity after done"}, post_act, 0);
        compare_mem(tag);
    endtask

    initial begin
        int cyc;
        vt.push_back(mk(2, 20, 3, 0, 0, 0, 1));    // basic copy
        vt.push_back(mk(30, 0, 4, 0, 0, 0, 1));    // wrap-around
        vt.push_back(mk(9, 9, 0, 0, 0, 0, 1));     // zero length
        vt.push_back(mk(0, 8, 2, 0, 0, 3, 1));     // start while busy
        vt.push_back(mk(0, 8, 2, 0, 0, 7, 1));     // start in DONE is lost
        vt.push_back(mk(4, 6, 8, 0, 0, 0, 1));     // forward overlap
        vt.push_back(mk(10, 5, 6, 0, 0, 0, 0));
        vt.push_back(mk(7, 3, 32, 0, 0, 0, 0));    // whole memory
        vt.push_back(mk(31, 31, 1, 0, 0, 0, 0));
`ifdef MEM_COPY_FILL_EN
        vt.push_back(mk(0, 21, 4, 1, 32'hCAD00FAB, 0, 1));
        vt.push_back(mk(3, 12, 32, 1, 32'h5A5A_0001, 0, 0));
        vt.push_back(mk(3, 12, 0, 1, 32'h1234_5678, 0, 0));
`endif
        for (int r = 0; r < 12; r++) begin
            bit f;
            f = 1'b0;
`ifdef MEM_COPY_FILL_EN
            f = ($urandom_range(0, 3) == 0);
`endif
            vt.push_back(mk($urandom_range(0, N - 1), $urandom_range(0, N - 1),
                            $urandom_range(0, N), f, $urandom, 0, 0));
        end

        // Reset state
        i_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", o_busy, 0);
        check("reset done", o_done, 0);
        check("reset mem_en", o_mem_en, 0);
        check("reset mem_wr_rd", o_mem_wr_rd, 0);
        check("reset mem_addr", o_mem_addr, 0);
        check("reset mem_din", o_mem_din, 0);
        i_rst = 1'b0;

        // Reset mid-copy: rst during cycle 4 (RD of word 1); only word 0 lands.
        preload(1'b1);
        ref_mem[10] = ref_mem[0];
        @(negedge clk);
        i_src_addr = 5'd0; i_dst_addr = 5'd10; i_len = 6'd5; i_fill_mode = 1'b0; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        cyc = 1;
        while (cyc < 4) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("mid-copy mem_en before reset", o_mem_en, 1);
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        check("abort busy", o_busy, 0);
        check("abort done", o_done, 0);
        check("abort mem_en", o_mem_en, 0);
        check("abort mem_wr_rd", o_mem_wr_rd, 0);
        check("abort mem_addr", o_mem_addr, 0);
        check("abort mem_din", o_mem_din, 0);
        repeat (4) @(posedge clk);
        #1;
        check("abort stays idle", o_busy | o_mem_en | o_done, 0);
        compare_mem("abort");

        for (int v = 0; v < vt.size(); v++) run_vec(vt[v], v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
